// File: rtl/cordic.sv
// Fully pipelined CORDIC rotator (rotation mode).
//
// Rotates the signed vector (xstart, ystart) by the binary angle zangle
// (full circle = 2^Z_WIDTH) and delivers one rotated vector per clock.
// Without gain compensation the result carries the CORDIC gain K ~ 1.64676.
//
// Ports:
//   clock    rising-edge clock
//   reset_n  asynchronous active-low reset, clears every pipeline register
//   xstart   signed x input (XY_WIDTH)
//   ystart   signed y input (XY_WIDTH)
//   zangle   binary angle (Z_WIDTH), 0x4000_0000 = +90 deg
//   xout     signed rotated x, saturated (XY_WIDTH)
//   yout     signed rotated y, saturated (XY_WIDTH)
//   done     high once the pipeline holds valid data since reset
//
// Optional feature macro: CORDIC_GAIN_COMP_EN
//   When defined, one extra register stage scales the result by 1/K
//   (19898 / 2^15, rounded, saturated); latency grows from ITER+1 to ITER+2.

module cordic #(
    parameter int XY_WIDTH = 16,
    parameter int Z_WIDTH  = 32,
    parameter int ITER     = 15
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [XY_WIDTH-1:0] xstart,
    input  logic [XY_WIDTH-1:0] ystart,
    input  logic [Z_WIDTH-1:0]  zangle,
    output logic [XY_WIDTH-1:0] xout,
    output logic [XY_WIDTH-1:0] yout,
    output logic                done
);

    // One guard bit absorbs the gain growth of the micro-rotations.
    localparam int XW = XY_WIDTH + 1;
    // Wide enough for the gain-compensation product of an XW value by 17 bits.
    localparam int PW = XW + 17;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int DLEN = ITER + 2;
`else
    localparam int DLEN = ITER + 1;
`endif

    localparam logic [Z_WIDTH-1:0]     QUARTER = Z_WIDTH'(1) << (Z_WIDTH - 2);
    localparam logic signed [PW-1:0]   SAT_MAX = PW'(2**(XY_WIDTH-1) - 1);
    localparam logic signed [PW-1:0]   SAT_MIN = ~SAT_MAX;

    // atan(2^-i) / (2*pi) * 2^32, rounded. Beyond i = 11 the cubic term of
    // the arctangent series is below 0.01 LSB, so 2^32/(2*pi) >> i suffices.
    function automatic logic [Z_WIDTH-1:0] atan_of(input int i);
        longint unsigned a32;
        int up;
        int dn;
        case (i)
            0:       a32 = 64'h2000_0000;
            1:       a32 = 64'h12E4_051E;
            2:       a32 = 64'h09FB_385B;
            3:       a32 = 64'h0511_11D4;
            4:       a32 = 64'h028B_0D43;
            5:       a32 = 64'h0145_D7E1;
            6:       a32 = 64'h00A2_F61E;
            7:       a32 = 64'h0051_7C55;
            8:       a32 = 64'h0028_BE53;
            9:       a32 = 64'h0014_5F2F;
            10:      a32 = 64'h000A_2F98;
            11:      a32 = 64'h0005_17CC;
            default: a32 = (64'd683565276 + (64'd1 << (i - 1))) >> i;
        endcase
        // Rescale the 32-bit table to the configured angle width.
        up = (Z_WIDTH > 32) ? Z_WIDTH - 32 : 0;
        dn = (Z_WIDTH < 32) ? 32 - Z_WIDTH : 0;
        return Z_WIDTH'(((a32 << up) + ((64'd1 << dn) >> 1)) >> dn);
    endfunction

    function automatic logic [XY_WIDTH-1:0] sat(input logic signed [PW-1:0] v);
        if (v > SAT_MAX) begin
            return {1'b0, {(XY_WIDTH-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, {(XY_WIDTH-1){1'b0}}};
        end else begin
            return v[XY_WIDTH-1:0];
        end
    endfunction

    logic signed [XW-1:0]  xs [0:ITER];
    logic signed [XW-1:0]  ys [0:ITER];
    // The residual angle after the last stage is not needed.
    logic [Z_WIDTH-1:0]    zs [0:ITER-1];
    logic [DLEN-1:0]       dsr;

    logic signed [XW-1:0]  xe;
    logic signed [XW-1:0]  ye;

    assign xe = $signed({xstart[XY_WIDTH-1], xstart});
    assign ye = $signed({ystart[XY_WIDTH-1], ystart});

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i <= ITER; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
            end
            for (int i = 0; i < ITER; i++) begin
                zs[i] <= '0;
            end
            dsr <= '0;
        end else begin
            // Stage 0: fold the angle into [-90, +90) so the micro-rotations
            // (which only cover about +/-99.9 deg) converge.
            case (zangle[Z_WIDTH-1 -: 2])
                2'b01: begin
                    xs[0] <= -ye;
                    ys[0] <= xe;
                    zs[0] <= zangle - QUARTER;
                end
                2'b10: begin
                    xs[0] <= ye;
                    ys[0] <= -xe;
                    zs[0] <= zangle + QUARTER;
                end
                default: begin
                    xs[0] <= xe;
                    ys[0] <= ye;
                    zs[0] <= zangle;
                end
            endcase

            for (int i = 0; i < ITER; i++) begin
                if (zs[i][Z_WIDTH-1]) begin
                    xs[i+1] <= xs[i] + (ys[i] >>> i);
                    ys[i+1] <= ys[i] - (xs[i] >>> i);
                    if (i < ITER - 1) begin
                        zs[i+1] <= zs[i] + atan_of(i);
                    end
                end else begin
                    xs[i+1] <= xs[i] - (ys[i] >>> i);
                    ys[i+1] <= ys[i] + (xs[i] >>> i);
                    if (i < ITER - 1) begin
                        zs[i+1] <= zs[i] - atan_of(i);
                    end
                end
            end

            dsr <= {dsr[DLEN-2:0], 1'b1};
        end
    end

    assign done = dsr[DLEN-1];

`ifdef CORDIC_GAIN_COMP_EN
    // round(2^15 / K)
    localparam logic signed [PW-1:0] GAIN_INV   = PW'(19898);
    localparam logic signed [PW-1:0] ROUND_HALF = PW'(2**14);

    logic signed [PW-1:0]  xp;
    logic signed [PW-1:0]  yp;
    logic signed [PW-1:0]  xr;
    logic signed [PW-1:0]  yr;
    logic [XY_WIDTH-1:0]   xc;
    logic [XY_WIDTH-1:0]   yc;

    always_comb begin
        xp = PW'(xs[ITER]) * GAIN_INV;
        yp = PW'(ys[ITER]) * GAIN_INV;
        xr = (xp + ROUND_HALF) >>> 15;
        yr = (yp + ROUND_HALF) >>> 15;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            xc <= '0;
            yc <= '0;
        end else begin
            xc <= sat(xr);
            yc <= sat(yr);
        end
    end

    assign xout = xc;
    assign yout = yc;
`else
    assign xout = sat(PW'(xs[ITER]));
    assign yout = sat(PW'(ys[ITER]));
`endif

endmodule

// File: tb/tb_cordic.sv
// Directed bench for the cordic rotator: reset/done timing, exact latency,
// single vectors at the quadrant boundaries, streaming order, asynchronous
// reset mid-stream and output saturation.

module tb_cordic;

`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = 17;
    localparam int M    = 1200;   // 1200 at unit gain
    localparam int M45  = 849;    // 1200 * cos 45
    localparam int MC30 = 1039;   // 1200 * cos 30
    localparam int MS30 = 600;    // 1200 * sin 30
`else
    localparam int LAT  = 16;
    localparam int M    = 1976;   // 1200 * K
    localparam int M45  = 1397;   // 1200 * K * cos 45
    localparam int MC30 = 1711;   // 1200 * K * cos 30
    localparam int MS30 = 988;    // 1200 * K * sin 30
`endif
    localparam int TOL = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] xstart = '0;
    logic [15:0] ystart = '0;
    logic [31:0] zangle = '0;
    logic [15:0] xout;
    logic [15:0] yout;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    cordic dut (
        .clock   (clock),
        .reset_n (reset_n),
        .xstart  (xstart),
        .ystart  (ystart),
        .zangle  (zangle),
        .xout    (xout),
        .yout    (yout),
        .done    (done)
    );

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    task automatic check(input string tag, input int got, input int exp, input int tol);
        n_checks++;
        if (got - exp > tol || exp - got > tol) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic run_vec(input string tag, input int x, input int y,
                           input logic [31:0] z, input int ex, input int ey);
        xstart = 16'(x);
        ystart = 16'(y);
        zangle = z;
        repeat (LAT) step();
        check({tag, ".x"}, sx(xout), ex, TOL);
        check({tag, ".y"}, sx(yout), ey, TOL);
    endtask

    initial begin
        // Reset held.
        repeat (3) step();
        check("rst.x", sx(xout), 0, 0);
        check("rst.y", sx(yout), 0, 0);
        check("rst.done", int'(done), 0, 0);

        // Release: done stays low until the LAT-th edge.
        reset_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            step();
            check($sformatf("done@%0d", k), int'(done), (k == LAT) ? 1 : 0, 0);
            if (k == 1) begin
                check("rel.x", sx(xout), 0, 0);
            end
        end

        // First vector with exact latency: still zero one edge early.
        xstart = 16'd1200;
        ystart = 16'd0;
        zangle = 32'h0000_0000;
        repeat (LAT - 1) step();
        check("lat_early.x", sx(xout), 0, 0);
        step();
        check("a0.x", sx(xout), M, TOL);
        check("a0.y", sx(yout), 0, TOL);

        run_vec("a90",   1200, 0, 32'h4000_0000, 0, M);
        run_vec("am90",  1200, 0, 32'hC000_0000, 0, -M);
        run_vec("a45",   1200, 0, 32'h2000_0000, M45, M45);
        run_vec("a120",  1200, 0, 32'h5555_5555, -(M / 2), MC30);
        run_vec("am120", 1200, 0, 32'hAAAA_AAAB, -(M / 2), -MC30);
        run_vec("a180",  1200, 0, 32'h8000_0000, -M, 0);

        // Streaming: four angles on consecutive cycles, then hold 30 deg.
        xstart = 16'd1200;
        ystart = 16'd0;
        zangle = 32'h0000_0000; step();
        zangle = 32'h1555_5555; step();
        zangle = 32'h2AAA_AAAA; step();
        zangle = 32'h4000_0000; step();
        zangle = 32'h1555_5555;
        repeat (LAT - 4) step();
        check("s0.x",  sx(xout), M, TOL);
        check("s0.y",  sx(yout), 0, TOL);
        step();
        check("s30.x", sx(xout), MC30, TOL);
        check("s30.y", sx(yout), MS30, TOL);
        step();
        check("s60.x", sx(xout), MS30, TOL);
        check("s60.y", sx(yout), MC30, TOL);
        step();
        check("s90.x", sx(xout), 0, TOL);
        check("s90.y", sx(yout), M, TOL);
        step();
        check("hold.x", sx(xout), MC30, TOL);

        // Asynchronous reset mid-stream: outputs clear without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("arst.x", sx(xout), 0, 0);
        check("arst.y", sx(yout), 0, 0);
        check("arst.done", int'(done), 0, 0);
        step();
        reset_n = 1'b1;

        // Saturation: K * 32767 exceeds the output range.
        run_vec("sat", 32767, 0, 32'h0000_0000, 32767, 0);
        check("sat.done", int'(done), 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
